// File: rtl/rf_arb_pkg.sv
// Shared widths and grant encoding for the regfile write-port controller.
package rf_arb_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int XLEN       = 32;
   localparam int NUM_REGS   = 32;

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_WB,
      GNT_MC
   } grant_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Busy-register scoreboard for multi-cycle destinations, in-flight counter and decode stall.
import rf_arb_pkg::*;

module rf_scoreboard #(
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [REG_ADDR_W-1:0] i_rs1_addr,
   input  logic [REG_ADDR_W-1:0] i_rs2_addr,
   input  logic [REG_ADDR_W-1:0] i_rd_addr,
   input  logic                  i_dec_valid,
   input  logic                  i_mc_issue,
   input  logic                  i_mc_accept,
   input  logic [REG_ADDR_W-1:0] i_mc_rd_addr,
   output logic                  o_dec_stall,
   output logic [NUM_REGS-1:0]   o_busy_vec
);
   localparam int CNT_W = 4;
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

   logic [NUM_REGS-1:0] r_busy;
   logic [CNT_W-1:0]    r_outstanding;
   logic                w_hazard;
   logic                w_full;
   logic                w_issueFire;
   logic [NUM_REGS-1:0] w_setMask;
   logic [NUM_REGS-1:0] w_clrMask;
   logic [NUM_REGS-1:0] w_busyNext;

   // Stall sees only registered state; a register freed this cycle unstalls next cycle.
   assign w_hazard = (i_rs1_addr != '0 && r_busy[i_rs1_addr]) ||
                     (i_rs2_addr != '0 && r_busy[i_rs2_addr]) ||
                     (i_rd_addr  != '0 && r_busy[i_rd_addr]);
   assign w_full      = i_mc_issue && (r_outstanding == MAX_CNT);
   assign o_dec_stall = i_dec_valid && (w_hazard || w_full);
   assign w_issueFire = i_mc_issue && i_dec_valid && !o_dec_stall;
   assign o_busy_vec  = r_busy;

   always_comb begin
      w_setMask = '0;
      w_clrMask = '0;
      if (w_issueFire && i_rd_addr != '0) w_setMask = NUM_REGS'(1) << i_rd_addr;
      if (i_mc_accept) w_clrMask = NUM_REGS'(1) << i_mc_rd_addr;
      w_busyNext    = (r_busy & ~w_clrMask) | w_setMask;
      w_busyNext[0] = 1'b0;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_busy        <= '0;
         r_outstanding <= '0;
      end else begin
         r_busy <= w_busyNext;
         if (w_issueFire && !i_mc_accept)
            r_outstanding <= r_outstanding + CNT_W'(1);
         else if (!w_issueFire && i_mc_accept)
            r_outstanding <= r_outstanding - CNT_W'(1);
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         assert (!(i_mc_accept && i_mc_rd_addr != '0 && !r_busy[i_mc_rd_addr]))
            else $error("MC accept of non-busy register x%0d", i_mc_rd_addr);
         assert (!(i_mc_accept && !w_issueFire && r_outstanding == '0))
            else $error("outstanding MC counter underflow");
      end
   end
`endif
endmodule

// File: rtl/rf_wb_scoreboard_arb.sv
// Regfile write-port arbiter (WB vs multi-cycle unit) with anti-starvation freeze and scoreboard.
// Optional perf counters are built only when RF_ARB_PERF_EN is defined.
import rf_arb_pkg::*;

module rf_wb_scoreboard_arb #(
   parameter int MAX_OUTSTANDING = 4,
   parameter int STARVE_MAX      = 3
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [REG_ADDR_W-1:0] i_dec_rs1_addr,
   input  logic [REG_ADDR_W-1:0] i_dec_rs2_addr,
   input  logic [REG_ADDR_W-1:0] i_dec_rd_addr,
   input  logic                  i_dec_valid,
   output logic                  o_dec_stall,
   input  logic                  i_mc_issue,
   input  logic                  i_wb_valid,
   input  logic [REG_ADDR_W-1:0] i_wb_rd_addr,
   input  logic [XLEN-1:0]       i_wb_rd_data,
   output logic                  o_wb_freeze,
   input  logic                  i_mc_valid,
   input  logic [REG_ADDR_W-1:0] i_mc_rd_addr,
   input  logic [XLEN-1:0]       i_mc_rd_data,
   output logic                  o_mc_ready,
   output logic [REG_ADDR_W-1:0] o_rd_addr,
   output logic [XLEN-1:0]       o_rd_data,
   output logic                  o_rd_wren,
   output logic [NUM_REGS-1:0]   o_busy_vec,
   output logic [XLEN-1:0]       o_perf_conflict,
   output logic [XLEN-1:0]       o_perf_freeze
);
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   grant_t     w_grant;
   logic       w_freeze;
   logic       w_mcAccept;
   logic [3:0] r_starveCnt;

   // Once MC has been denied STARVE_MAX cycles in a row it takes the port over WB.
   assign w_freeze    = !i_rst && (r_starveCnt == STARVE_LIM) && i_mc_valid;
   assign o_wb_freeze = w_freeze;
   assign w_mcAccept  = i_mc_valid && o_mc_ready;

   always_comb begin
      w_grant = GNT_NONE;
      if (!i_rst) begin
         if (w_freeze)        w_grant = GNT_MC;
         else if (i_wb_valid) w_grant = GNT_WB;
         else if (i_mc_valid) w_grant = GNT_MC;
      end
   end

   always_comb begin
      o_rd_wren  = 1'b0;
      o_rd_addr  = '0;
      o_rd_data  = '0;
      o_mc_ready = 1'b0;
      case (w_grant)
         GNT_WB: begin
            o_rd_wren = 1'b1;
            o_rd_addr = i_wb_rd_addr;
            o_rd_data = i_wb_rd_data;
         end
         GNT_MC: begin
            o_rd_wren  = 1'b1;
            o_rd_addr  = i_mc_rd_addr;
            o_rd_data  = i_mc_rd_data;
            o_mc_ready = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || !i_mc_valid || w_mcAccept)
         r_starveCnt <= '0;
      else if (r_starveCnt != STARVE_LIM)
         r_starveCnt <= r_starveCnt + 4'd1;
   end

   rf_scoreboard #(
      .MAX_OUTSTANDING (MAX_OUTSTANDING)
   ) u_scoreboard (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_rs1_addr   (i_dec_rs1_addr),
      .i_rs2_addr   (i_dec_rs2_addr),
      .i_rd_addr    (i_dec_rd_addr),
      .i_dec_valid  (i_dec_valid),
      .i_mc_issue   (i_mc_issue),
      .i_mc_accept  (w_mcAccept),
      .i_mc_rd_addr (i_mc_rd_addr),
      .o_dec_stall  (o_dec_stall),
      .o_busy_vec   (o_busy_vec)
   );

`ifdef RF_ARB_PERF_EN
   logic [XLEN-1:0] r_perfConflict;
   logic [XLEN-1:0] r_perfFreeze;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_perfConflict <= '0;
         r_perfFreeze   <= '0;
      end else begin
         if (i_wb_valid && i_mc_valid) r_perfConflict <= r_perfConflict + XLEN'(1);
         if (w_freeze)                 r_perfFreeze   <= r_perfFreeze + XLEN'(1);
      end
   end

   assign o_perf_conflict = r_perfConflict;
   assign o_perf_freeze   = r_perfFreeze;
`else
   assign o_perf_conflict = '0;
   assign o_perf_freeze   = '0;
`endif
endmodule

// File: tb/tb_rf_wb_scoreboard_arb.sv
// Scoreboard bench: stimulus pushes expected outputs from a queue-based model, a negedge monitor compares.
module tb_rf_wb_scoreboard_arb;
   localparam int MAX_OUT = 4;
   localparam int STARVE  = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  decRs1 = '0, decRs2 = '0, decRd = '0;
   logic        decValid = 1'b0, mcIssue = 1'b0;
   logic        wbValid = 1'b0;
   logic [4:0]  wbRd = '0;
   logic [31:0] wbData = '0;
   logic        mcValid = 1'b0;
   logic [4:0]  mcRd = '0;
   logic [31:0] mcData = '0;
   logic        decStall, wbFreeze, mcReady, rdWren;
   logic [4:0]  rdAddr;
   logic [31:0] rdData, busyVec, perfConflict, perfFreeze;

   always #5 clk = ~clk;

   rf_wb_scoreboard_arb #(
      .MAX_OUTSTANDING (MAX_OUT),
      .STARVE_MAX      (STARVE)
   ) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_dec_rs1_addr  (decRs1),
      .i_dec_rs2_addr  (decRs2),
      .i_dec_rd_addr   (decRd),
      .i_dec_valid     (decValid),
      .o_dec_stall     (decStall),
      .i_mc_issue      (mcIssue),
      .i_wb_valid      (wbValid),
      .i_wb_rd_addr    (wbRd),
      .i_wb_rd_data    (wbData),
      .o_wb_freeze     (wbFreeze),
      .i_mc_valid      (mcValid),
      .i_mc_rd_addr    (mcRd),
      .i_mc_rd_data    (mcData),
      .o_mc_ready      (mcReady),
      .o_rd_addr       (rdAddr),
      .o_rd_data       (rdData),
      .o_rd_wren       (rdWren),
      .o_busy_vec      (busyVec),
      .o_perf_conflict (perfConflict),
      .o_perf_freeze   (perfFreeze)
   );

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } mcOp_t;

   typedef struct {
      logic        stall, freeze, ready, wren;
      logic [4:0]  addr;
      logic [31:0] data, busy, pconf, pfrz;
   } expect_t;

   // Model: pending MC ops in issue order (its length is the in-flight count), busy flags, denial streak.
   mcOp_t       mcQ[$];
   expect_t     expQ[$];
   bit          busyM[32];
   int          starveM = 0;
   logic [31:0] perfConfM = '0, perfFrzM = '0;
   bit          mcHolding = 1'b0;
   int          vectors = 0, miscompares = 0;
   bit          countFreeze = 1'b0;
   int          freezeSeen = 0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   // One clock of stimulus; the MC unit presents its oldest op and holds it until accepted.
   task automatic applyStimulus(input bit r, input bit dv, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input bit iss, input bit wv, input logic [4:0] wrd,
                                input logic [31:0] wdat, input bit mcReq);
      expect_t e;
      bit mcv, fire, conflict;
      @(posedge clk);
      #1;
      mcv      = !r && (mcQ.size() > 0) && (mcReq || mcHolding);
      rst      = r;
      decValid = dv && !r;
      decRs1   = rs1;
      decRs2   = rs2;
      decRd    = rd;
      mcIssue  = iss && !r;
      wbValid  = wv && !r;
      wbRd     = wrd;
      wbData   = wdat;
      mcValid  = mcv;
      mcRd     = mcv ? mcQ[0].rd : 5'd0;
      mcData   = mcv ? mcQ[0].data : 32'd0;

      for (int i = 0; i < 32; i++) e.busy[i] = busyM[i];
      e.stall = decValid && ((rs1 != 0 && busyM[rs1]) || (rs2 != 0 && busyM[rs2]) ||
                             (rd != 0 && busyM[rd]) || (mcIssue && mcQ.size() == MAX_OUT));
      e.freeze = !r && mcv && (starveM == STARVE);
      e.ready  = 1'b0;
      e.wren   = 1'b0;
      e.addr   = '0;
      e.data   = '0;
      if (!r && (e.freeze || (!wbValid && mcv))) begin
         e.ready = 1'b1;
         e.wren  = 1'b1;
         e.addr  = mcQ[0].rd;
         e.data  = mcQ[0].data;
      end else if (!r && wbValid) begin
         e.wren = 1'b1;
         e.addr = wrd;
         e.data = wdat;
      end
`ifdef RF_ARB_PERF_EN
      e.pconf = perfConfM;
      e.pfrz  = perfFrzM;
`else
      e.pconf = '0;
      e.pfrz  = '0;
`endif
      expQ.push_back(e);

      conflict = wbValid && mcv;
      fire     = mcIssue && decValid && !e.stall;
      if (r) begin
         mcQ.delete();
         for (int i = 0; i < 32; i++) busyM[i] = 1'b0;
         starveM   = 0;
         perfConfM = '0;
         perfFrzM  = '0;
         mcHolding = 1'b0;
      end else begin
         if (conflict) perfConfM++;
         if (e.freeze) perfFrzM++;
         starveM   = (mcv && !e.ready) ? ((starveM < STARVE) ? starveM + 1 : STARVE) : 0;
         mcHolding = mcv && !e.ready;
         if (e.ready) begin
            busyM[mcQ[0].rd] = 1'b0;
            void'(mcQ.pop_front());
         end
         if (fire) begin
            mcOp_t op;
            op.rd   = rd;
            op.data = $urandom;
            if (rd != 0) busyM[rd] = 1'b1;
            mcQ.push_back(op);
         end
      end
   endtask

   always @(negedge clk) begin
      expect_t e;
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         checkOutput("dec_stall", 32'(decStall), 32'(e.stall));
         checkOutput("wb_freeze", 32'(wbFreeze), 32'(e.freeze));
         checkOutput("mc_ready", 32'(mcReady), 32'(e.ready));
         checkOutput("rd_wren", 32'(rdWren), 32'(e.wren));
         checkOutput("rd_addr", 32'(rdAddr), 32'(e.addr));
         checkOutput("rd_data", rdData, e.data);
         checkOutput("busy_vec", busyVec, e.busy);
         checkOutput("perf_conflict", perfConflict, e.pconf);
         checkOutput("perf_freeze", perfFreeze, e.pfrz);
      end
      if (countFreeze) freezeSeen += int'(wbFreeze);
   end

   initial begin
      for (int i = 0; i < 32; i++) busyM[i] = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_busy", busyVec, 32'd0);
      checkOutput("reset_wren", 32'(rdWren), 32'd0);
      checkOutput("reset_ready", 32'(mcReady), 32'd0);
      checkOutput("reset_perf", perfConflict | perfFreeze, 32'd0);

      // Plain WB write goes straight through.
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd5, 32'hDEADBEEF, 0);
      @(negedge clk);
      checkOutput("x5_addr", 32'(rdAddr), 32'd5);
      checkOutput("x5_data", rdData, 32'hDEADBEEF);
      checkOutput("x5_ready", 32'(mcReady), 32'd0);

      // RAW on an MC destination holds decode until the accept has been registered.
      applyStimulus(0, 1, 0, 0, 5'd7, 1, 0, 0, 0, 0);
      repeat (3) applyStimulus(0, 1, 5'd7, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 5'd7, 0, 0, 0, 0, 0, 0, 1);
      @(negedge clk);
      checkOutput("raw_stall_on_accept", 32'(decStall), 32'd1);
      checkOutput("raw_accept_addr", 32'(rdAddr), 32'd7);
      applyStimulus(0, 1, 5'd7, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("raw_stall_drop", 32'(decStall), 32'd0);

      // Fill the in-flight limit, then a fifth issue waits one cycle past the freeing accept.
      for (int k = 1; k <= 4; k++) applyStimulus(0, 1, 0, 0, 5'(k), 1, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 5'd9, 1, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("full_stall", 32'(decStall), 32'd1);
      applyStimulus(0, 1, 0, 0, 5'd9, 1, 0, 0, 0, 1);
      @(negedge clk);
      checkOutput("full_stall_accept", 32'(decStall), 32'd1);
      applyStimulus(0, 1, 0, 0, 5'd9, 1, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("full_issue", 32'(decStall), 32'd0);

      // Ten cycles of WB and MC both requesting: MC wins every fourth cycle.
      countFreeze = 1'b1;
      for (int k = 0; k < 10; k++) applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'(k + 10), $urandom, 1);
      @(negedge clk);
      #1;
      countFreeze = 1'b0;
      checkOutput("freeze_cycles", 32'(freezeSeen), 32'd2);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
`ifdef RF_ARB_PERF_EN
      checkOutput("perf_conflict_10", perfConflict, 32'd10);
      checkOutput("perf_freeze_2", perfFreeze, 32'd2);
`else
      checkOutput("perf_conflict_off", perfConflict, 32'd0);
      checkOutput("perf_freeze_off", perfFreeze, 32'd0);
`endif

      // Randomised traffic with small register ranges to force hazards, plus occasional resets.
      for (int n = 0; n < 700; n++)
         applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
                       5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                       $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 6, 5'($urandom_range(0, 31)),
                       $urandom, $urandom_range(0, 2) == 0);

      @(negedge clk);
      #1;
      checkOutput("monitor_drained", 32'(expQ.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/rf_wb_scoreboard_arb.md
Name: rf_wb_scoreboard_arb

Overview:
- Controller in front of the 32x32 register file's single write port.
- Arbitrates the port between the in-order pipeline writeback (WB) and one long-latency multi-cycle unit (MC: load miss / mul-div).
- Keeps a per-register busy scoreboard for MC destinations and generates the decode stall.
- Drives the regfile write port directly; the regfile's same-cycle write bypass handles read-after-write.

Parameters:
- MAX_OUTSTANDING, 4, max MC ops in flight (issued, not yet written back); range 1..15.
- STARVE_MAX, 3, consecutive cycles MC may be denied before WB is frozen for one cycle; range 1..15.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_dec_rs1_addr  in  5  decode-stage source 1.
- i_dec_rs2_addr  in  5  decode-stage source 2.
- i_dec_rd_addr  in  5  decode-stage destination.
- i_dec_valid  in  1  decode holds a valid instruction.
- o_dec_stall  out  1  decode must hold (RAW/WAW on busy reg, or MC issue not possible).
- i_mc_issue  in  1  decode issues an MC op this cycle (qualified internally by !o_dec_stall).
- i_wb_valid  in  1  pipeline WB write request.
- i_wb_rd_addr  in  5  WB destination.
- i_wb_rd_data  in  32  WB data.
- o_wb_freeze  out  1  WB stage and upstream hold this cycle; WB request is not written.
- i_mc_valid  in  1  MC result valid.
- i_mc_rd_addr  in  5  MC destination.
- i_mc_rd_data  in  32  MC data.
- o_mc_ready  out  1  MC result accepted this cycle.
- o_rd_addr  out  5  to regfile i_rd_addr.
- o_rd_data  out  32  to regfile i_rd_data.
- o_rd_wren  out  1  to regfile i_rd_wren.
- o_busy_vec  out  32  scoreboard, debug.
- o_perf_conflict  out  32  perf counter (see Optional Feature).
- o_perf_freeze  out  32  perf counter (see Optional Feature).

Behaviour:
- Reset (i_rst high at a posedge):
  - busy_vec=0, outstanding=0, starve_cnt=0.
  - Combinational outputs reduce to: o_rd_wren=0, o_mc_ready=0, o_wb_freeze=0.
  - o_dec_stall follows i_dec_valid/i_mc_issue and the cleared scoreboard.
  - Perf counters=0.
  - Reset mid-operation discards outstanding MC tracking; the MC unit is reset by the same i_rst.
- Arbiter is combinational, zero latency, from registered starve_cnt:
  - FREEZE = (starve_cnt == STARVE_MAX) && i_mc_valid.
  - If FREEZE: grant MC. o_wb_freeze=1, o_mc_ready=1.
  - Else if i_wb_valid: grant WB. o_mc_ready=0.
  - Else if i_mc_valid: grant MC. o_mc_ready=1.
  - Else: o_rd_wren=0.
  - o_rd_* carry the granted source's addr/data. o_rd_wren=1 on any grant.
  - Writes to x0 are passed through; the regfile ignores them.
  - Idle o_rd_addr/o_rd_data=0.
- starve_cnt:
  - Increments when i_mc_valid && !o_mc_ready, saturating at STARVE_MAX.
  - Clears on an MC accept or when !i_mc_valid.
  - o_wb_freeze is therefore at most 1 cycle per STARVE_MAX+1 cycles.
- MC handshake: MC holds valid/addr/data stable until o_mc_ready. Accept = i_mc_valid && o_mc_ready.
- Scoreboard update, at the clock edge:
  - issue_fire = i_mc_issue && i_dec_valid && !o_dec_stall.
  - issue_fire with rd!=0 sets busy[rd].
  - MC accept clears busy[i_mc_rd_addr].
  - Same register set and cleared in one cycle: set wins.
  - busy[0] is always 0.
- outstanding:
  - issue_fire (any rd, including 0) increments it.
  - MC accept decrements it.
  - Both in one cycle: unchanged.
- o_dec_stall is combinational from registered state. It is high when i_dec_valid and any of:
  - busy[rs1] with rs1!=0;
  - busy[rs2] with rs2!=0;
  - busy[rd] with rd!=0 (WAW);
  - i_mc_issue && outstanding==MAX_OUTSTANDING.
- No same-cycle scoreboard bypass: a register cleared this cycle unstalls decode next cycle. The regfile bypass covers the data.
- Decode must not issue a non-MC op to a busy rd; the WAW stall guarantees this.
- Assertions: MC accept with busy[rd]==0 (rd!=0) is an error, as is outstanding underflow.

Optional Feature:
- Macro RF_ARB_PERF_EN.
- Defined:
  - o_perf_conflict counts cycles with i_wb_valid && i_mc_valid.
  - o_perf_freeze counts cycles with o_wb_freeze=1.
  - Both are 32-bit, wrap at 2^32, and clear on i_rst.
- Undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Package rf_arb_pkg: REG_ADDR_W=5, XLEN=32, NUM_REGS=32, and enum grant_t {GNT_NONE, GNT_WB, GNT_MC}.
- One sub-module, rf_scoreboard: busy_vec, outstanding counter, and the stall logic.
- The arbiter, starve counter and perf counters stay in the top level.

Test Plan:
- Reset, then WB-only writes x5=0xDEADBEEF: o_rd_wren=1, o_rd_addr=5, o_rd_data=0xDEADBEEF same cycle; o_mc_ready=0.
- MC issue rd=7, then decode rs1=7: o_dec_stall=1 until MC accept of x7. busy[7] clears the next cycle; stall drops that cycle.
- Continuous WB plus MC valid with STARVE_MAX=3: MC is denied 3 cycles. On the 4th cycle o_wb_freeze=1, o_mc_ready=1, o_rd_addr=MC rd. The pattern repeats with period 4.
- Issue 4 MC ops to rd 1..4 (MAX_OUTSTANDING=4), then a 5th issue to rd=9: stalled. Same-cycle accept of rd=1 does not unstall that cycle; the 5th issues the next cycle.
- MC accept of rd=3 in the same cycle as issue_fire to rd=3 is illegal (blocked by the WAW stall). Instead check an accept of rd=3 with an issue to rd=6: busy[3]=0, busy[6]=1, outstanding unchanged.
- With RF_ARB_PERF_EN, 10 conflict cycles at STARVE_MAX=3: o_perf_conflict=10, o_perf_freeze=2. Without the macro: both ports read 0.
